// File: rtl/hamming_secded_if.sv
// Streaming bus between the channel side and the SECDED decoder.
// Carries the codeword input handshake and the decoded result handshake.
interface hamming_secded_if #(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned PAR_W  = 5
);
  localparam int unsigned CODE_W = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] code_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              err_single;
  logic              err_double;
  logic [PAR_W-1:0]  err_pos;

  modport master (
    output in_valid, code_in, out_ready,
    input  in_ready, out_valid, data_out, err_single, err_double, err_pos
  );

  modport slave (
    input  in_valid, code_in, out_ready,
    output in_ready, out_valid, data_out, err_single, err_double, err_pos
  );
endinterface

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SECDED Hamming decoder with valid/ready streaming and global EN hold.
// Define HAMMING_ERR_STATS_EN to add the saturating error statistics counters.
module hamming_secded_decoder #(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned PAR_W  = 5
`ifdef HAMMING_ERR_STATS_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
`ifdef HAMMING_ERR_STATS_EN
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double,
  input  logic             cnt_clr,
`endif
  hamming_secded_if.slave  bus
);

  localparam int unsigned    CODE_W  = DATA_W + PAR_W + 1;
  localparam logic [PAR_W-1:0] MAX_POS = PAR_W'(CODE_W - 1);

  // Hamming position of data bit k: k-th non-power-of-two position from 1 upward.
  function automatic int data_pos(input int k);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int i = 1; i < int'(CODE_W); i++) begin
      if ((i & (i - 1)) != 0) begin
        if (n == k) pos = i;
        n++;
      end
    end
    return pos;
  endfunction

  logic              adv1;
  logic              adv2;
  logic [PAR_W-1:0]  syn_c;
  logic              par_c;
  logic [DATA_W-1:0] raw_c;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_par;

  logic              flip_c;
  logic              single_c;
  logic              double_c;
  logic [DATA_W-1:0] fixed_c;

  assign adv2         = EN & (~bus.out_valid | bus.out_ready);
  assign adv1         = EN & (~s1_valid | adv2);
  assign bus.in_ready = adv1;

  // Syndrome is the XOR of the indices of all set bits; P0 covers the whole word.
  always_comb begin
    syn_c = '0;
    for (int i = 1; i < int'(CODE_W); i++) begin
      if (bus.code_in[i]) syn_c = syn_c ^ PAR_W'(i);
    end
    par_c = ^bus.code_in;
  end

  for (genvar k = 0; k < int'(DATA_W); k++) begin : g_data
    localparam int POS = data_pos(k);
    assign raw_c[k]   = bus.code_in[POS];
    assign fixed_c[k] = s1_data[k] ^ (flip_c && (s1_syn == PAR_W'(POS)));
  end

  // Odd overall parity means one flipped bit, unless the syndrome points past the word.
  assign flip_c   = s1_par && (s1_syn != '0) && (s1_syn <= MAX_POS);
  assign single_c = s1_par && (s1_syn <= MAX_POS);
  assign double_c = (s1_syn != '0) && (!s1_par || (s1_syn > MAX_POS));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data <= raw_c;
        s1_syn  <= syn_c;
        s1_par  <= par_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.data_out   <= '0;
      bus.err_single <= 1'b0;
      bus.err_double <= 1'b0;
      bus.err_pos    <= '0;
    end else if (adv2) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.data_out   <= fixed_c;
        bus.err_single <= single_c;
        bus.err_double <= double_c;
        bus.err_pos    <= s1_syn;
      end
    end
  end

`ifdef HAMMING_ERR_STATS_EN
  logic out_fire_c;
  assign out_fire_c = bus.out_valid & bus.out_ready & EN;

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (EN) begin
      if (cnt_clr) begin
        cnt_single <= '0;
        cnt_double <= '0;
      end else if (out_fire_c) begin
        if (bus.err_single && (cnt_single != '1)) cnt_single <= cnt_single + CNT_W'(1);
        if (bus.err_double && (cnt_double != '1)) cnt_double <= cnt_double + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Bench for hamming_secded_decoder: vector table, stall/EN/reset sequences and a random stream,
// all checked through an expected-result queue.
module tb_hamming_secded_decoder;

  localparam int unsigned DATA_W = 13;
  localparam int unsigned PAR_W  = 5;
  localparam int unsigned CODE_W = DATA_W + PAR_W + 1;
`ifdef HAMMING_ERR_STATS_EN
  localparam int unsigned CNT_W  = 4;
  logic [CNT_W-1:0] cnt_single;
  logic [CNT_W-1:0] cnt_double;
  logic             cnt_clr;
`endif

  typedef struct {
    logic [CODE_W-1:0] code;
    logic [DATA_W-1:0] data;
    logic              single;
    logic              dbl;
    logic [PAR_W-1:0]  pos;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic EN;
  int   checks   = 0;
  int   failures = 0;
  int   cyc_cnt  = 0;
  vec_t q[$];
  vec_t cur;
  vec_t exp_v;
  vec_t tbl[11];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  hamming_secded_if #(.DATA_W(DATA_W), .PAR_W(PAR_W)) bus ();

  hamming_secded_decoder #(
    .DATA_W(DATA_W),
    .PAR_W (PAR_W)
`ifdef HAMMING_ERR_STATS_EN
    ,
    .CNT_W (CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .EN        (EN),
`ifdef HAMMING_ERR_STATS_EN
    .cnt_single(cnt_single),
    .cnt_double(cnt_double),
    .cnt_clr   (cnt_clr),
`endif
    .bus       (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CODE_W-1:0] bit_at(input int p);
    logic [CODE_W-1:0] m;
    m    = '0;
    m[p] = 1'b1;
    return m;
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] cw;
    logic [PAR_W-1:0]  s;
    int                k;
    cw = '0;
    s  = '0;
    k  = 0;
    for (int i = 1; i < int'(CODE_W); i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i] = d[k];
        k++;
      end
    end
    for (int i = 1; i < int'(CODE_W); i++) if (cw[i]) s = s ^ PAR_W'(i);
    for (int p = 0; p < int'(PAR_W); p++) if ((1 << p) < int'(CODE_W)) cw[1 << p] = s[p];
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int                k;
    d = '0;
    k = 0;
    for (int i = 1; i < int'(CODE_W); i++) begin
      if ((i & (i - 1)) != 0) begin
        d[k] = cw[i];
        k++;
      end
    end
    return d;
  endfunction

  function automatic vec_t mk(input logic [CODE_W-1:0] code, input logic [DATA_W-1:0] data,
                              input logic single, input logic dbl, input logic [PAR_W-1:0] pos);
    vec_t v;
    v.code = code; v.data = data; v.single = single; v.dbl = dbl; v.pos = pos;
    return v;
  endfunction

  function automatic vec_t rnd_vec(input int force_kind);
    vec_t              v;
    logic [DATA_W-1:0] d;
    int                kind;
    int                p;
    int                p2;
    d    = DATA_W'($urandom);
    kind = (force_kind >= 0) ? force_kind : int'($urandom_range(0, 3));
    p    = int'($urandom_range(1, CODE_W - 1));
    p2   = int'($urandom_range(1, CODE_W - 2));
    if (p2 >= p) p2++;
    v = mk(encode(d), d, 1'b0, 1'b0, '0);
    case (kind)
      1: begin v.code ^= bit_at(p); v.single = 1'b1; v.pos = PAR_W'(p); end
      2: begin
        v.code ^= bit_at(p) ^ bit_at(p2);
        v.dbl = 1'b1; v.pos = PAR_W'(p ^ p2); v.data = extract(v.code);
      end
      3: begin
        v.code ^= bit_at(0) ^ bit_at(p);
        v.dbl = 1'b1; v.pos = PAR_W'(p); v.data = extract(v.code);
      end
      default: ;
    endcase
    return v;
  endfunction

  // Monitor: inputs and outputs are stable between the drive point and the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready && EN) begin
        if (q.size() == 0) begin
          check("unexpected_output", 32'(bus.out_valid), 32'(0));
        end else begin
          exp_v = q.pop_front();
          check("data_out",   32'(bus.data_out),   32'(exp_v.data));
          check("err_single", 32'(bus.err_single), 32'(exp_v.single));
          check("err_double", 32'(bus.err_double), 32'(exp_v.dbl));
          check("err_pos",    32'(bus.err_pos),    32'(exp_v.pos));
          check("flags_excl", 32'(bus.err_single & bus.err_double), 32'(0));
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(cur);
    end
  end

  // Called just after a rising edge; returns just after the edge that accepts v.
  task automatic send(input vec_t v);
    int n;
    n            = 0;
    cur          = v;
    bus.code_in  = v.code;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("send_timeout", 32'(bus.in_ready), 32'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n              = 0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    while ((q.size() != 0 || bus.out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(q.size()), 32'(0));
  endtask

  initial begin
    int c0;
    int idx;
    vec_t v;

    rst           = 1'b1;
    EN            = 1'b1;
    bus.in_valid  = 1'b0;
    bus.code_in   = '0;
    bus.out_ready = 1'b1;
`ifdef HAMMING_ERR_STATS_EN
    cnt_clr       = 1'b0;
`endif

    tbl[0]  = mk('0, 13'h0000, 1'b0, 1'b0, 5'd0);
    tbl[1]  = mk(encode(13'h1ABC) ^ bit_at(7), 13'h1ABC, 1'b1, 1'b0, 5'd7);
    tbl[2]  = mk(encode(13'h1ABC) ^ bit_at(0), 13'h1ABC, 1'b1, 1'b0, 5'd0);
    tbl[3]  = mk(encode(13'h0555) ^ bit_at(3) ^ bit_at(5), 13'h0556, 1'b0, 1'b1, 5'd6);
    tbl[4]  = mk(encode(13'h1FFF), 13'h1FFF, 1'b0, 1'b0, 5'd0);
    tbl[5]  = mk(encode(13'h1FFF) ^ bit_at(18), 13'h1FFF, 1'b1, 1'b0, 5'd18);
    tbl[6]  = mk(encode(13'h0001) ^ bit_at(1), 13'h0001, 1'b1, 1'b0, 5'd1);
    tbl[7]  = mk(encode(13'h1234) ^ bit_at(16), 13'h1234, 1'b1, 1'b0, 5'd16);
    tbl[8]  = mk(encode(13'h0AAA) ^ bit_at(16) ^ bit_at(3) ^ bit_at(0), 13'h0AAB, 1'b0, 1'b1, 5'd19);
    tbl[9]  = mk(encode(13'h0F0F) ^ bit_at(0) ^ bit_at(9), 13'h0F1F, 1'b0, 1'b1, 5'd9);
    tbl[10] = mk(encode(13'h1ABC) ^ bit_at(3), 13'h1ABC, 1'b1, 1'b0, 5'd3);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid",  32'(bus.out_valid),  32'(0));
    check("rst_data_out",   32'(bus.data_out),   32'(0));
    check("rst_err_single", 32'(bus.err_single), 32'(0));
    check("rst_err_double", 32'(bus.err_double), 32'(0));
    check("rst_err_pos",    32'(bus.err_pos),    32'(0));
`ifdef HAMMING_ERR_STATS_EN
    check("rst_cnt_single", 32'(cnt_single), 32'(0));
    check("rst_cnt_double", 32'(cnt_double), 32'(0));
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));

    // Clean word latency: result appears after the edge following acceptance.
    @(posedge clk);
    #1;
    send(tbl[0]);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("latency_s1", 32'(bus.out_valid), 32'(0));
    @(negedge clk);
    check("latency_s2", 32'(bus.out_valid), 32'(1));

    // Table vectors back to back at full rate.
    @(posedge clk);
    #1;
    c0 = cyc_cnt;
    for (int i = 1; i < 11; i++) send(tbl[i]);
    check("throughput_cycles", 32'(cyc_cnt - c0), 32'(10));
    drain();

    // Backpressure: two words fill the pipe, the third is refused and outputs hold.
    bus.out_ready = 1'b0;
    send(tbl[1]);
    send(tbl[4]);
    cur          = tbl[5];
    bus.code_in  = tbl[5].code;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready",  32'(bus.in_ready),  32'(0));
      check("stall_out_valid", 32'(bus.out_valid), 32'(1));
      check("stall_data_hold", 32'(bus.data_out),  32'(13'h1ABC));
      check("stall_pos_hold",  32'(bus.err_pos),   32'(7));
    end
    @(posedge clk);
    #1;
    EN            = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("en0_in_ready",  32'(bus.in_ready),  32'(0));
      check("en0_out_valid", 32'(bus.out_valid), 32'(1));
      check("en0_data_hold", 32'(bus.data_out),  32'(13'h1ABC));
      check("en0_no_xfer",   32'(q.size()),      32'(2));
    end
    @(posedge clk);
    #1;
    EN = 1'b1;
    send(tbl[5]);
    drain();

    // Reset with words in both stages discards them.
    send(tbl[2]);
    send(tbl[3]);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_flush_out_valid", 32'(bus.out_valid), 32'(0));
    end
    check("rst_flush_queue", 32'(q.size()), 32'(0));

    // Random stream with random gaps and random consumer backpressure.
    @(posedge clk);
    #1;
    idx = 0;
    v   = rnd_vec(-1);
    for (int n = 0; n < 2000 && idx < 60; n++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = ($urandom_range(0, 4) != 0);
      cur           = v;
      bus.code_in   = v.code;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        idx++;
        v = rnd_vec(-1);
      end
      @(posedge clk);
      #1;
    end
    check("random_sent", 32'(idx), 32'(60));
    drain();

`ifdef HAMMING_ERR_STATS_EN
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("clr_cnt_single", 32'(cnt_single), 32'(0));
    check("clr_cnt_double", 32'(cnt_double), 32'(0));
    for (int i = 0; i < 20; i++) send(rnd_vec(1));
    for (int i = 0; i < 3; i++) send(rnd_vec(2));
    drain();
    check("sat_cnt_single", 32'(cnt_single), 32'(15));
    check("cnt_double",     32'(cnt_double), 32'(3));
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("clr2_cnt_single", 32'(cnt_single), 32'(0));
    check("clr2_cnt_double", 32'(cnt_double), 32'(0));
`endif

    check("final_queue", 32'(q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
